// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle CPU controller: FSM states,
// instruction indices of the one-hot decode vector, select encodings and ALU opcodes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, MDU_WAIT, EXC
    } state_e;

    // One-hot instruction indices (0..30 legacy map, 31..34 multiply/divide)
    localparam int I_ADD   = 0;
    localparam int I_ADDU  = 1;
    localparam int I_SUB   = 2;
    localparam int I_SUBU  = 3;
    localparam int I_AND   = 4;
    localparam int I_OR    = 5;
    localparam int I_XOR   = 6;
    localparam int I_NOR   = 7;
    localparam int I_SLT   = 8;
    localparam int I_SLTU  = 9;
    localparam int I_SLL   = 10;
    localparam int I_SRL   = 11;
    localparam int I_SRA   = 12;
    localparam int I_SLLV  = 13;
    localparam int I_SRLV  = 14;
    localparam int I_SRAV  = 15;
    localparam int I_JR    = 16;
    localparam int I_ADDI  = 17;
    localparam int I_ADDIU = 18;
    localparam int I_ANDI  = 19;
    localparam int I_ORI   = 20;
    localparam int I_XORI  = 21;
    localparam int I_LUI   = 22;
    localparam int I_LW    = 23;
    localparam int I_SW    = 24;
    localparam int I_BEQ   = 25;
    localparam int I_BNE   = 26;
    localparam int I_SLTI  = 27;
    localparam int I_SLTIU = 28;
    localparam int I_J     = 29;
    localparam int I_JAL   = 30;
    localparam int I_MULT  = 31;
    localparam int I_MULTU = 32;
    localparam int I_DIV   = 33;
    localparam int I_DIVU  = 34;

    // Indices above this carry no static decode and are not retained after DECODE
    localparam int N_KNOWN = I_DIVU + 1;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_EXC    = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        WA_RD = 2'd0,
        WA_RT = 2'd1,
        WA_RA = 2'd2
    } waddr_e;

    typedef enum logic [1:0] {
        WD_ALU = 2'd0,
        WD_MEM = 2'd1,
        WD_PC8 = 2'd2
    } wdata_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

endpackage

// File: rtl/ctrl_static_decode.sv
// Combinational map from the one-hot instruction vector to datapath selects,
// ALU operation and the instruction-class flags the sequencer branches on.
module ctrl_static_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_CW = 4
) (
    input  logic [N_KNOWN-1:0] instr,
    output logic [ALU_CW-1:0]  alu_control,
    output logic               op1_sel,
    output logic               op2_sel,
    output logic [1:0]         waddr_sel,
    output logic [1:0]         wdata_sel,
    output logic               is_j,
    output logic               is_jr,
    output logic               is_jal,
    output logic               is_branch,
    output logic               is_bne,
    output logic               is_mdu,
    output logic               is_lw,
    output logic               is_sw
);

    alu_op_e op;
    logic    itype;

    assign is_j      = instr[I_J];
    assign is_jr     = instr[I_JR];
    assign is_jal    = instr[I_JAL];
    assign is_bne    = instr[I_BNE];
    assign is_branch = instr[I_BEQ] | instr[I_BNE];
    assign is_mdu    = instr[I_MULT] | instr[I_MULTU] | instr[I_DIV] | instr[I_DIVU];
    assign is_lw     = instr[I_LW];
    assign is_sw     = instr[I_SW];

    assign itype = instr[I_ADDI] | instr[I_ADDIU] | instr[I_ANDI] | instr[I_ORI]
                 | instr[I_XORI] | instr[I_LUI]   | instr[I_SLTI] | instr[I_SLTIU]
                 | instr[I_LW]   | instr[I_SW];

    // NOTE: every combinational output is given a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        op = ALU_ADD;
        if (instr[I_SUB] | instr[I_SUBU] | is_branch)        op = ALU_SUB;
        else if (instr[I_AND] | instr[I_ANDI])               op = ALU_AND;
        else if (instr[I_OR] | instr[I_ORI])                 op = ALU_OR;
        else if (instr[I_XOR] | instr[I_XORI])               op = ALU_XOR;
        else if (instr[I_NOR])                               op = ALU_NOR;
        else if (instr[I_SLT] | instr[I_SLTI])               op = ALU_SLT;
        else if (instr[I_SLTU] | instr[I_SLTIU])             op = ALU_SLTU;
        else if (instr[I_SLL] | instr[I_SLLV])               op = ALU_SLL;
        else if (instr[I_SRL] | instr[I_SRLV])               op = ALU_SRL;
        else if (instr[I_SRA] | instr[I_SRAV])               op = ALU_SRA;
        else if (instr[I_LUI])                               op = ALU_LUI;
    end

    always_comb begin
        waddr_sel = WA_RD;
        wdata_sel = WD_ALU;
        if (is_jal) begin
            waddr_sel = WA_RA;
            wdata_sel = WD_PC8;
        end else if (itype) begin
            waddr_sel = WA_RT;
            wdata_sel = is_lw ? WD_MEM : WD_ALU;
        end
    end

    assign alu_control = ALU_CW'(op);
    // Immediate-shamt shifts take operand 1 from the instruction field
    assign op1_sel     = instr[I_SLL] | instr[I_SRL] | instr[I_SRA];
    assign op2_sel     = itype;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with ack handshakes
// to instruction memory, data memory and the MDU, plus illegal and bus-timeout traps.
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int N_INSTR     = 54,
    parameter int ALU_CW      = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_INSTR-1:0] decoded_instr,
    input  logic               alu_zero,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    input  logic               mdu_done,
    output logic               imem_req,
    output logic               ir_w,
    output logic               pc_w,
    output logic [1:0]         pc_sel,
    output logic               dmem_r,
    output logic               dmem_w,
    output logic               regfile_w,
    output logic [1:0]         ref_waddr_signal,
    output logic [1:0]         ref_wdata_signal,
    output logic [ALU_CW-1:0]  alu_control,
    output logic               alu_operand1_signal,
    output logic               alu_operand2_signal,
    output logic               mdu_start,
    output logic               retire,
    output logic               exc_illegal,
    output logic               exc_bus
);

    state_e             state, state_d;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_d;
    logic [N_KNOWN-1:0] instr_q, instr_cur;
    logic               timed_out;
    pc_sel_e            pc_sel_v;
    logic               is_j, is_jr, is_jal, is_branch, is_bne, is_mdu, is_lw, is_sw;

    // DECODE steers from the live vector; every later state uses the latched copy
    assign instr_cur = (state == DECODE) ? decoded_instr[N_KNOWN-1:0] : instr_q;

    ctrl_static_decode #(.ALU_CW(ALU_CW)) u_decode (
        .instr       (instr_cur),
        .alu_control (alu_control),
        .op1_sel     (alu_operand1_signal),
        .op2_sel     (alu_operand2_signal),
        .waddr_sel   (ref_waddr_signal),
        .wdata_sel   (ref_wdata_signal),
        .is_j        (is_j),
        .is_jr       (is_jr),
        .is_jal      (is_jal),
        .is_branch   (is_branch),
        .is_bne      (is_bne),
        .is_mdu      (is_mdu),
        .is_lw       (is_lw),
        .is_sw       (is_sw)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            instr_q  <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            if (state == DECODE) instr_q <= decoded_instr[N_KNOWN-1:0];
        end
    end

    // Reaching MEM_TIMEOUT-1 here means this is the MEM_TIMEOUT-th cycle without an ack
    assign timed_out = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        if (state_d != state)                 wait_cnt_d = '0;
        else if (state == FETCH || state == MEM) wait_cnt_d = wait_cnt + CNT_W'(1);
        else                                  wait_cnt_d = wait_cnt;
    end

    always_comb begin
        state_d     = state;
        imem_req    = 1'b0;
        ir_w        = 1'b0;
        pc_w        = 1'b0;
        pc_sel_v    = PC_PLUS4;
        dmem_r      = 1'b0;
        dmem_w      = 1'b0;
        regfile_w   = 1'b0;
        mdu_start   = 1'b0;
        retire      = 1'b0;
        exc_illegal = 1'b0;
        exc_bus     = 1'b0;

        case (state)
            IDLE: state_d = FETCH;

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_w    = 1'b1;
                    state_d = DECODE;
                end else if (timed_out) begin
                    exc_bus = 1'b1;
                    state_d = EXC;
                end
            end

            DECODE: begin
                if (!$onehot(decoded_instr)) begin
                    exc_illegal = 1'b1;
                    state_d     = EXC;
                end else if (is_j || is_jr) begin
                    pc_w     = 1'b1;
                    pc_sel_v = PC_JUMP;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end else if (is_jal) begin
                    state_d = WB;
                end else begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                if (is_branch) begin
                    pc_w     = 1'b1;
                    pc_sel_v = (alu_zero ^ is_bne) ? PC_BRANCH : PC_PLUS4;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end else if (is_mdu) begin
                    mdu_start = 1'b1;
                    state_d   = MDU_WAIT;
                end else if (is_lw || is_sw) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end

            MEM: begin
                dmem_r = is_lw;
                dmem_w = is_sw;
                if (dmem_ack) begin
                    if (is_sw) begin
                        pc_w    = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (timed_out) begin
                    exc_bus = 1'b1;
                    state_d = EXC;
                end
            end

            MDU_WAIT: begin
                if (mdu_done) begin
                    pc_w    = 1'b1;
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end

            WB: begin
                regfile_w = 1'b1;
                pc_w      = 1'b1;
                pc_sel_v  = is_jal ? PC_JUMP : PC_PLUS4;
                retire    = 1'b1;
                state_d   = FETCH;
            end

            EXC: begin
                pc_w     = 1'b1;
                pc_sel_v = PC_EXC;
                state_d  = FETCH;
            end

            default: state_d = IDLE;
        endcase
    end

    assign pc_sel = pc_sel_v;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a driver pushes the expected
// per-instruction summary, a monitor rebuilds it from the strobes and compares.
module tb_multicycle_controller;
    import cpu_ctrl_pkg::*;

    localparam int N = 54;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] decoded_instr = '0;
    logic         alu_zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0, mdu_done = 1'b0;
    logic         imem_req, ir_w, pc_w, dmem_r, dmem_w, regfile_w, mdu_start;
    logic         retire, exc_illegal, exc_bus, alu_operand1_signal, alu_operand2_signal;
    logic [1:0]   pc_sel, ref_waddr_signal, ref_wdata_signal;
    logic [3:0]   alu_control;

    multicycle_controller #(.N_INSTR(N), .ALU_CW(4), .MEM_TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .decoded_instr(decoded_instr), .alu_zero(alu_zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .mdu_done(mdu_done),
        .imem_req(imem_req), .ir_w(ir_w), .pc_w(pc_w), .pc_sel(pc_sel),
        .dmem_r(dmem_r), .dmem_w(dmem_w), .regfile_w(regfile_w),
        .ref_waddr_signal(ref_waddr_signal), .ref_wdata_signal(ref_wdata_signal),
        .alu_control(alu_control), .alu_operand1_signal(alu_operand1_signal),
        .alu_operand2_signal(alu_operand2_signal), .mdu_start(mdu_start),
        .retire(retire), .exc_illegal(exc_illegal), .exc_bus(exc_bus)
    );

    always #5 clk = ~clk;

    // Expected per-instruction outcome; alu/ops of -1 means "not checked"
    typedef struct {
        string name;
        int lat; int pcs; int ret; int regw; int wa; int wd; int alu; int ops;
        int mdu; int dr; int dw; int ill; int bus; int ir;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic abort(input string name);
        checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    function automatic exp_t mk(input string n, input int lat, input int pcs, input int ret,
                                input int regw, input int wa, input int wd, input int alu,
                                input int ops, input int mdu, input int dr, input int dw,
                                input int ill, input int bus, input int ir);
        exp_t e;
        e.name = n; e.lat = lat; e.pcs = pcs; e.ret = ret; e.regw = regw; e.wa = wa;
        e.wd = wd; e.alu = alu; e.ops = ops; e.mdu = mdu; e.dr = dr; e.dw = dw;
        e.ill = ill; e.bus = bus; e.ir = ir;
        return e;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Monitor: one instruction runs from the first imem_req cycle to its pc_w cycle
    bit active = 0;
    int lat, ir_at, got_alu, got_ops;
    int n_ir, n_mdu, n_dr, n_dw, n_regw, n_ill, n_bus, n_ret;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
        end else begin
            if (!active && imem_req) begin
                active = 1; lat = 0; ir_at = -10; got_alu = -1; got_ops = -1;
                n_ir = 0; n_mdu = 0; n_dr = 0; n_dw = 0; n_regw = 0; n_ill = 0; n_bus = 0; n_ret = 0;
            end
            if (active) begin
                lat++;
                if (ir_w) ir_at = lat;
                if (lat == ir_at + 2) begin
                    got_alu = int'(alu_control);
                    got_ops = int'({alu_operand1_signal, alu_operand2_signal});
                end
                n_ir   += int'(ir_w);      n_mdu += int'(mdu_start);
                n_dr   += int'(dmem_r);    n_dw  += int'(dmem_w);
                n_regw += int'(regfile_w); n_ill += int'(exc_illegal);
                n_bus  += int'(exc_bus);   n_ret += int'(retire);
                if (pc_w) begin
                    active = 0;
                    check("scoreboard has entry", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check({e.name, " latency"}, lat, e.lat);
                        check({e.name, " pc_sel"}, int'(pc_sel), e.pcs);
                        check({e.name, " retire count"}, n_ret, e.ret);
                        check({e.name, " regfile_w count"}, n_regw, e.regw);
                        if (e.regw == 1) begin
                            check({e.name, " ref_waddr"}, int'(ref_waddr_signal), e.wa);
                            check({e.name, " ref_wdata"}, int'(ref_wdata_signal), e.wd);
                        end
                        if (e.alu >= 0) check({e.name, " alu_control"}, got_alu, e.alu);
                        if (e.ops >= 0) check({e.name, " operand selects"}, got_ops, e.ops);
                        check({e.name, " mdu_start count"}, n_mdu, e.mdu);
                        check({e.name, " dmem_r cycles"}, n_dr, e.dr);
                        check({e.name, " dmem_w cycles"}, n_dw, e.dw);
                        check({e.name, " exc_illegal count"}, n_ill, e.ill);
                        check({e.name, " exc_bus count"}, n_bus, e.bus);
                        check({e.name, " ir_w count"}, n_ir, e.ir);
                    end
                end
            end
        end
    end

    // sel: 0 = imem_req, 1 = dmem_r|dmem_w, 2 = mdu_start; returns at the negedge of the n-th high cycle
    task automatic count_high(input int sel, input int n, input string name);
        int seen = 0;
        int budget = 0;
        while (seen < n) begin
            @(negedge clk);
            case (sel)
                0:       seen += int'(imem_req);
                1:       seen += int'(dmem_r | dmem_w);
                default: seen += int'(mdu_start);
            endcase
            budget++;
            if (budget > 600) abort(name);
        end
    endtask

    task automatic wait_pc_w(input string name);
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
            if (budget > 400) abort(name);
        end while (!pc_w);
    endtask

    // id/dd: wait cycles before the imem/dmem ack (-1 = never); md: cycles from mdu_start to mdu_done
    task automatic run(input exp_t e, input logic [N-1:0] vec, input int id, input int dd,
                       input int md, input logic z);
        sb.push_back(e);
        decoded_instr = vec;
        alu_zero      = z;
        imem_ack      = (id == 0);
        dmem_ack      = (dd == 0);
        mdu_done      = 1'b0;
        if (id > 0) begin
            count_high(0, id, e.name);
            @(posedge clk); #1 imem_ack = 1'b1;
        end
        if (dd > 0) begin
            count_high(1, dd, e.name);
            @(posedge clk); #1 dmem_ack = 1'b1;
        end
        if (md > 0) begin
            count_high(2, 1, e.name);
            repeat (md) @(posedge clk);
            #1 mdu_done = 1'b1;
        end
        wait_pc_w(e.name);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        abort("global watchdog");
    end

    initial begin
        logic [N-1:0] two_hot;
        two_hot = oh(I_ADDU) | oh(I_SUB);

        repeat (2) @(negedge clk);
        check("reset strobes", int'({imem_req, ir_w, pc_w, dmem_r, dmem_w, regfile_w,
                                     mdu_start, retire, exc_illegal, exc_bus}), 0);
        check("reset selects", int'({pc_sel, ref_waddr_signal, ref_wdata_signal, alu_control,
                                     alu_operand1_signal, alu_operand2_signal}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset imem_req", int'(imem_req), 0);

        //          name            lat pcs ret rw wa wd alu ops mdu dr  dw ill bus ir
        run(mk("addu",            4,  0,  1, 1, 0, 0,  0,  0, 0,  0,  0, 0,  0, 1), oh(I_ADDU), 0, 0, 0, 0);
        run(mk("sll",             4,  0,  1, 1, 0, 0,  8,  2, 0,  0,  0, 0,  0, 1), oh(I_SLL), 0, 0, 0, 0);
        run(mk("addiu slow fetch",6,  0,  1, 1, 1, 0,  0,  1, 0,  0,  0, 0,  0, 1), oh(I_ADDIU), 2, 0, 0, 0);
        run(mk("lw dmem wait 3",  8,  0,  1, 1, 1, 1,  0,  1, 0,  4,  0, 0,  0, 1), oh(23), 0, 3, 0, 0);
        run(mk("sw",              4,  0,  1, 0, 0, 0,  0,  1, 0,  0,  1, 0,  0, 1), oh(24), 0, 0, 0, 0);
        run(mk("beq taken",       3,  1,  1, 0, 0, 0,  1,  0, 0,  0,  0, 0,  0, 1), oh(25), 0, 0, 0, 1);
        run(mk("beq not taken",   3,  0,  1, 0, 0, 0,  1,  0, 0,  0,  0, 0,  0, 1), oh(25), 0, 0, 0, 0);
        run(mk("bne taken",       3,  1,  1, 0, 0, 0,  1,  0, 0,  0,  0, 0,  0, 1), oh(26), 0, 0, 0, 0);
        run(mk("bne not taken",   3,  0,  1, 0, 0, 0,  1,  0, 0,  0,  0, 0,  0, 1), oh(26), 0, 0, 0, 1);
        run(mk("jal",             3,  2,  1, 1, 2, 2, -1, -1, 0,  0,  0, 0,  0, 1), oh(30), 0, 0, 0, 0);
        run(mk("jr",              2,  2,  1, 0, 0, 0, -1, -1, 0,  0,  0, 0,  0, 1), oh(16), 0, 0, 0, 0);
        run(mk("j",               2,  2,  1, 0, 0, 0, -1, -1, 0,  0,  0, 0,  0, 1), oh(29), 0, 0, 0, 0);
        run(mk("div 33 stall",   36,  0,  1, 0, 0, 0, -1, -1, 1,  0,  0, 0,  0, 1), oh(33), 0, 0, 33, 0);
        run(mk("illegal zero",    3,  3,  0, 0, 0, 0, -1, -1, 0,  0,  0, 1,  0, 1), '0, 0, 0, 0, 0);
        run(mk("illegal two-hot", 3,  3,  0, 0, 0, 0, -1, -1, 0,  0,  0, 1,  0, 1), two_hot, 0, 0, 0, 0);
        run(mk("fetch timeout", 256,  3,  0, 0, 0, 0, -1, -1, 0,  0,  0, 0,  1, 0), oh(I_ADDU), -1, 0, 0, 0);
        run(mk("lw mem timeout",259,  3,  0, 0, 0, 0,  0,  1, 0, 255, 0, 0,  1, 1), oh(23), 0, -1, 0, 0);

        // Reset asserted mid-MEM must drop the data request without waiting for a clock edge
        decoded_instr = oh(23);
        imem_ack      = 1'b1;
        dmem_ack      = 1'b0;
        count_high(1, 1, "lw before reset");
        check("dmem_r before reset", int'(dmem_r), 1);
        #2 rst_n = 1'b0;
        #1;
        check("dmem_r after async reset", int'(dmem_r), 0);
        check("strobes after async reset", int'({imem_req, pc_w, retire, regfile_w}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run(mk("addu after reset",4,  0,  1, 1, 0, 0,  0,  0, 0,  0,  0, 0,  0, 1), oh(I_ADDU), 0, 0, 0, 0);

        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
